// File: rtl/jtag_uart_bridge_pkg.sv
// Shared types/constants for the JTAG UART bridge.
// Ports: none (package only).
package jtag_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_DATA,
    RD_CTRL
  } state_t;

  // Which side was served last; RD_CTRL counts as TX-side work.
  typedef enum logic {
    OP_RX,
    OP_TX
  } op_t;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  localparam int RVALID_BIT = 15;
  localparam int WSPACE_MSB = 31;
  localparam int WSPACE_LSB = 16;

endpackage

// File: rtl/jtag_uart_bridge_if.sv
// Avalon-MM bus between the bridge (master) and the JTAG UART core (slave).
// Ports: address/read/write/writedata out of master; readdata/waitrequest in.
interface jtag_uart_bridge_if;
  logic        av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_waitrequest;

  modport master (
    output av_address,
    output av_read,
    output av_write,
    output av_writedata,
    input  av_readdata,
    input  av_waitrequest
  );

  modport slave (
    input  av_address,
    input  av_read,
    input  av_write,
    input  av_writedata,
    output av_readdata,
    output av_waitrequest
  );
endinterface

// File: rtl/jtag_uart_bridge_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte FIFO.
// Ports: clk, rst, push/din, pop, head (0 when empty), full, empty.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? 8'h00 : mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push & ~do_pop)      cnt <= cnt + 1'b1;
      else if (~do_push & do_pop) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/jtag_uart_bridge.sv
// JTAG UART bridge: DMA byte handshake <-> Avalon-MM JTAG UART, RX/TX FIFOs.
// Ports: Clk, Reset, jtag_* DMA side, av (Avalon master); rx_bytes/tx_bytes
// only with JTAG_BRIDGE_STATS_EN defined.
module jtag_uart_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  jtag_Din,
  input  logic        jtag_WE,
  input  logic        jtag_Act,
  output logic [7:0]  jtag_Dout,
  output logic        jtag_A,
  output logic        jtag_R,
  jtag_uart_bridge_if.master av
`ifdef JTAG_BRIDGE_STATS_EN
  ,
  output logic [31:0] rx_bytes,
  output logic [31:0] tx_bytes
`endif
);
  state_t      state, state_n;
  op_t         last_op;
  logic [15:0] wspace;

  logic       rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0] rx_head, tx_head;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic       accept, tx_elig, rd_elig, wr_go, rd_go;

  logic        req_addr, req_rd, req_wr;
  logic [31:0] req_wdata;

  assign accept  = (state != IDLE) & ~av.av_waitrequest;
  assign rx_push = (state == RD_DATA) & accept
                 & av.av_readdata[RVALID_BIT];
  assign rx_pop  = jtag_Act & ~jtag_WE & ~rx_empty;
  assign tx_push = jtag_Act & jtag_WE & ~tx_full;
  assign tx_pop  = (state == WR_DATA) & accept;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk   (Clk),
    .rst   (Reset),
    .push  (rx_push),
    .din   (av.av_readdata[7:0]),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk   (Clk),
    .rst   (Reset),
    .push  (tx_push),
    .din   (jtag_Din),
    .pop   (tx_pop),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign jtag_Dout = rx_head;
  assign jtag_A    = ~rx_empty;
  assign jtag_R    = ~tx_full;

  // Alternation only holds back a side when the other one can go,
  // so a full RX never stalls TX and wspace polls are not starved.
  assign tx_elig = ~tx_empty;
  assign rd_elig = ~rx_full;
  assign wr_go   = tx_elig & (wspace != 16'h0)
                 & ((last_op != OP_TX) | ~rd_elig);
  assign rd_go   = rd_elig & ((last_op != OP_RX) | ~tx_elig);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      last_op <= OP_RX;
      wspace  <= 16'h0;
    end else begin
      state <= state_n;
      if (accept)
        last_op <= (state == RD_DATA) ? OP_RX : OP_TX;
      if ((state == RD_CTRL) & accept)
        wspace <= av.av_readdata[WSPACE_MSB:WSPACE_LSB];
      else if (tx_pop)
        wspace <= wspace - 16'h1;
    end
  end

  always_comb begin
    state_n   = state;
    req_addr  = REG_DATA;
    req_rd    = 1'b0;
    req_wr    = 1'b0;
    req_wdata = 32'h0;
    unique case (state)
      IDLE: begin
        if (wr_go)
          state_n = WR_DATA;
        else if (rd_go)
          state_n = RD_DATA;
        else if (tx_elig & (wspace == 16'h0))
          state_n = RD_CTRL;
      end
      WR_DATA: begin
        req_wr    = 1'b1;
        req_wdata = {24'h0, tx_head};
        if (accept) state_n = IDLE;
      end
      RD_DATA: begin
        req_rd = 1'b1;
        if (accept) state_n = IDLE;
      end
      RD_CTRL: begin
        req_rd   = 1'b1;
        req_addr = REG_CTRL;
        if (accept) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign av.av_address   = req_addr;
  assign av.av_read      = req_rd;
  assign av.av_write     = req_wr;
  assign av.av_writedata = req_wdata;

`ifdef JTAG_BRIDGE_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_bytes <= 32'h0;
      tx_bytes <= 32'h0;
    end else begin
      if (rx_push) rx_bytes <= rx_bytes + 32'h1;
      if (tx_pop)  tx_bytes <= tx_bytes + 32'h1;
    end
  end
`endif
endmodule
